// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register file with same-cycle write bypass and
// an instruction retire counter.
//
// Ports:
//   clk, rst                    single clock; synchronous active-high reset
//   wwreg, wm2reg               write enable / write-data select (1 = memory)
//   wdata_out, waluout          memory load data / ALU result candidates
//   wrdrt                       destination register number
//   WB_ins_type, WB_ins_number  retiring instruction tags (type 0 = bubble)
//   rs_addr/rs_data, rt_addr/rt_data, dbg_addr/dbg_data
//                               three combinational read ports with bypass
//   wb_value                    selected write-back value (combinational)
//   retire_count                wrapping count of retired non-bubble instructions
//   last_ins_type/number        tags of the most recently retired instruction
module wb_regfile #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wwreg,
    input  logic             wm2reg,
    input  logic [31:0]      wdata_out,
    input  logic [31:0]      waluout,
    input  logic [4:0]       wrdrt,
    input  logic [3:0]       WB_ins_type,
    input  logic [3:0]       WB_ins_number,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data,
    output logic [31:0]      wb_value,
    output logic [CNT_W-1:0] retire_count,
    output logic [3:0]       last_ins_type,
    output logic [3:0]       last_ins_number
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned ADDR_W = 5;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        last_type_q, last_type_d;
    logic [3:0]        last_num_q, last_num_d;
    logic              wr_hit;
    logic              retire;

    // Write-back mux is independent of the write enable.
    assign wb_value = wm2reg ? wdata_out : waluout;

    // A write to r0 is neither stored nor bypassed.
    assign wr_hit = wwreg && (wrdrt != ADDR_W'(0));
    assign retire = (WB_ins_type != 4'd0);

    // Read ports: r0 forced to zero, then bypass, then array. Bypass ignores
    // rst so readers see the in-flight value even during a reset cycle.
    assign rs_data  = (rs_addr == ADDR_W'(0))         ? '0       :
                      (wr_hit && (rs_addr == wrdrt))  ? wb_value : regs_q[rs_addr];
    assign rt_data  = (rt_addr == ADDR_W'(0))         ? '0       :
                      (wr_hit && (rt_addr == wrdrt))  ? wb_value : regs_q[rt_addr];
    assign dbg_data = (dbg_addr == ADDR_W'(0))        ? '0       :
                      (wr_hit && (dbg_addr == wrdrt)) ? wb_value : regs_q[dbg_addr];

    // Next-state: reset wins over any concurrent write or retire.
    always_comb begin
        regs_d      = regs_q;
        cnt_d       = cnt_q;
        last_type_d = last_type_q;
        last_num_d  = last_num_q;
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_d[i] = '0;
            end
            cnt_d       = '0;
            last_type_d = '0;
            last_num_d  = '0;
        end else begin
            if (wr_hit) begin
                regs_d[wrdrt] = wb_value;
            end
            if (retire) begin
                cnt_d       = cnt_q + CNT_W'(1);
                last_type_d = WB_ins_type;
                last_num_d  = WB_ins_number;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= regs_d[i];
        end
        cnt_q       <= cnt_d;
        last_type_q <= last_type_d;
        last_num_q  <= last_num_d;
    end

    assign retire_count    = cnt_q;
    assign last_ins_type   = last_type_q;
    assign last_ins_number = last_num_q;

endmodule
